// File: rtl/muldiv_pkg.sv
// Shared CPU package: funct field encodings used by the ALU and the HI/LO
// multiply/divide unit, plus small helpers common to both.
package muldiv_pkg;

   typedef logic [5:0] funct_t;

   localparam funct_t FUNCT_MFHI  = 6'h10;
   localparam funct_t FUNCT_MTHI  = 6'h11;
   localparam funct_t FUNCT_MFLO  = 6'h12;
   localparam funct_t FUNCT_MTLO  = 6'h13;
   localparam funct_t FUNCT_MULT  = 6'h18;
   localparam funct_t FUNCT_MULTU = 6'h19;
   localparam funct_t FUNCT_DIV   = 6'h1A;
   localparam funct_t FUNCT_DIVU  = 6'h1B;

   // Sign fix-up recorded at operation start and applied in the final cycle.
   // For a multiply only neg_lo is meaningful: it negates the whole product.
   typedef struct packed {
      logic is_div;
      logic neg_lo;
      logic neg_hi;
   } fix_ctrl_t;

   function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
      return (is_signed && x[31]) ? (~x + 32'd1) : x;
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// CPU-side handshake and result bus of the HI/LO multiply/divide unit.
interface muldiv_if;
   import muldiv_pkg::*;

   logic        start;
   funct_t      fncode;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] r;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, fncode, a, b,
      input  r, busy, done, hi, lo
   );

   modport slave (
      input  start, fncode, a, b,
      output r, busy, done, hi, lo
   );

endinterface

// File: rtl/muldiv_iter.sv
// One iteration of the unsigned datapath: a shift-add multiply step or a
// restoring-division step over the {upper, lower} working pair.
module muldiv_iter (
   input  logic        is_div,
   input  logic [31:0] upper,
   input  logic [31:0] lower,
   input  logic [31:0] operand,
   output logic [31:0] upper_next,
   output logic [31:0] lower_next
);

   logic [32:0] sum;
   logic [32:0] shifted;
   logic [31:0] diff;
   logic        fits;

   always_comb begin
      // NOTE: every output of a combinational block gets a value before any
      // branch, so no path can leave it unassigned and infer a latch.
      upper_next = upper;
      lower_next = lower;

      // Multiply: add the multiplicand if the current multiplier bit is set,
      // then shift the 65-bit {carry, upper, lower} right by one.
      sum = {1'b0, upper} + (lower[0] ? {1'b0, operand} : 33'd0);

      // Divide: shift the next dividend bit into the partial remainder and
      // subtract the divisor if it fits. The remainder stays below the
      // divisor, so the 32-bit difference is exact whenever it is used.
      shifted = {upper, lower[31]};
      fits    = (shifted >= {1'b0, operand});
      diff    = shifted[31:0] - operand;

      if (is_div) begin
         upper_next = fits ? diff : shifted[31:0];
         lower_next = {lower[30:0], fits};
      end else begin
         upper_next = sum[32:1];
         lower_next = {sum[0], lower[31:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: 32-cycle iterative MULT/MULTU/DIV/DIVU, a sign
// fix-up cycle, and single-cycle MTHI/MTLO/MFHI/MFLO access.
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic     clk,
   input  logic     reset_n,
   muldiv_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t      state_q, state_d;
   logic [4:0]  count_q;
   logic [31:0] upper_q, lower_q, operand_q;
   logic [31:0] upper_next, lower_next;
   fix_ctrl_t   ctrl_q;
   logic [31:0] hi_q, lo_q;
   logic        done_q;

   logic        load_mul, load_div, write_mthi, write_mtlo, finish;
   logic        op_signed;
   logic [63:0] product;
   logic [31:0] fix_hi, fix_lo;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      load_mul   = 1'b0;
      load_div   = 1'b0;
      write_mthi = 1'b0;
      write_mtlo = 1'b0;
      finish     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               case (bus.fncode)
                  FUNCT_MULT, FUNCT_MULTU: begin load_mul = 1'b1; state_d = MUL; end
                  FUNCT_DIV,  FUNCT_DIVU:  begin load_div = 1'b1; state_d = DIV; end
                  FUNCT_MTHI:              write_mthi = 1'b1;
                  FUNCT_MTLO:              write_mtlo = 1'b1;
                  default: ;
               endcase
            end
         end
         MUL, DIV: begin
            if (count_q == 5'd31) state_d = FIX;
         end
         FIX: begin
            finish  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   assign op_signed = (bus.fncode == FUNCT_MULT) || (bus.fncode == FUNCT_DIV);

   muldiv_iter u_iter (
      .is_div     (ctrl_q.is_div),
      .upper      (upper_q),
      .lower      (lower_q),
      .operand    (operand_q),
      .upper_next (upper_next),
      .lower_next (lower_next)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: the working registers are reset as well, so an operation
      // aborted by reset leaves nothing behind for the next one to see.
      if (!reset_n) begin
         upper_q   <= '0;
         lower_q   <= '0;
         operand_q <= '0;
         count_q   <= '0;
         ctrl_q    <= '0;
      end else if (load_mul || load_div) begin
         upper_q        <= '0;
         lower_q        <= magnitude(bus.a, op_signed);
         operand_q      <= magnitude(bus.b, op_signed);
         count_q        <= '0;
         ctrl_q.is_div  <= load_div;
         if (load_div) begin
            // A zero divisor keeps the all-ones quotient un-negated.
            ctrl_q.neg_lo <= op_signed && (bus.a[31] ^ bus.b[31]) && (bus.b != '0);
            ctrl_q.neg_hi <= op_signed && bus.a[31];
         end else begin
            ctrl_q.neg_lo <= op_signed && (bus.a[31] ^ bus.b[31]);
            ctrl_q.neg_hi <= op_signed && (bus.a[31] ^ bus.b[31]);
         end
      end else if (state_q == MUL || state_q == DIV) begin
         upper_q <= upper_next;
         lower_q <= lower_next;
         count_q <= count_q + 5'd1;
      end
   end

   always_comb begin
      product = {upper_q, lower_q};
      if (ctrl_q.neg_lo) product = 64'd0 - product;
      if (ctrl_q.is_div) begin
         fix_lo = ctrl_q.neg_lo ? (32'd0 - lower_q) : lower_q;
         fix_hi = ctrl_q.neg_hi ? (32'd0 - upper_q) : upper_q;
      end else begin
         fix_lo = product[31:0];
         fix_hi = product[63:32];
      end
   end

   // -------------------------------------------------------- HI/LO, done
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= finish;
         if (finish) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
         end else begin
            if (write_mthi) hi_q <= bus.a;
            if (write_mtlo) lo_q <= bus.a;
         end
      end
   end

   always_comb begin
      case (bus.fncode)
         FUNCT_MFHI: bus.r = hi_q;
         FUNCT_MFLO: bus.r = lo_q;
         default:    bus.r = '0;
      endcase
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// multiply/divide traffic against an arithmetic reference model.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_errors;
   logic [31:0] exp_hi, exp_lo;

   muldiv_if bus ();

   muldiv_unit dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: plain integer arithmetic with the two documented
   // special cases handled explicitly.
   function automatic void model(input funct_t fn, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
      longint          sp;
      longint unsigned up;
      int              sa, sb, q, r;
      hi = exp_hi;
      lo = exp_lo;
      sa = a;
      sb = b;
      case (fn)
         FUNCT_MULT: begin
            sp = longint'(sa) * longint'(sb);
            hi = sp[63:32];
            lo = sp[31:0];
         end
         FUNCT_MULTU: begin
            up = {32'd0, a} * {32'd0, b};
            hi = up[63:32];
            lo = up[31:0];
         end
         FUNCT_DIV: begin
            if (b == 32'd0) begin
               lo = 32'hFFFF_FFFF; hi = a;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo = 32'h8000_0000; hi = 32'd0;
            end else begin
               q = sa / sb; r = sa % sb;
               lo = q; hi = r;
            end
         end
         FUNCT_DIVU: begin
            if (b == 32'd0) begin
               lo = 32'hFFFF_FFFF; hi = a;
            end else begin
               lo = a / b; hi = a % b;
            end
         end
         FUNCT_MTHI: hi = a;
         FUNCT_MTLO: lo = a;
         default: ;
      endcase
   endfunction

   // Single-cycle request (MTHI/MTLO/other); called and returns at posedge+1.
   task automatic run_short(input funct_t fn, input logic [31:0] a, input string tag);
      logic [31:0] eh, el;
      model(fn, a, 32'd0, eh, el);
      bus.start = 1'b1; bus.fncode = fn; bus.a = a; bus.b = $urandom;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.a = $urandom;
      check({tag, " busy"}, 32'(bus.busy), 32'd0);
      check({tag, " hi"}, bus.hi, eh);
      check({tag, " lo"}, bus.lo, el);
      exp_hi = eh; exp_lo = el;
   endtask

   // Multi-cycle op; optionally pulses a second request on busy cycle inj_cycle.
   task automatic run_long(input funct_t fn, input logic [31:0] a, input logic [31:0] b,
                           input int inj_cycle, input funct_t inj_fn, input logic [31:0] inj_a,
                           input string tag);
      logic [31:0] eh, el;
      int          cycles;
      model(fn, a, b, eh, el);
      bus.start = 1'b1; bus.fncode = fn; bus.a = a; bus.b = b;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
      cycles = 0;
      while (bus.busy === 1'b1 && cycles < 40) begin
         cycles++;
         check({tag, " hold hi"}, bus.hi, exp_hi);
         check({tag, " hold lo"}, bus.lo, exp_lo);
         check({tag, " no early done"}, 32'(bus.done), 32'd0);
         if (cycles == inj_cycle) begin
            bus.start = 1'b1; bus.fncode = inj_fn; bus.a = inj_a;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      check({tag, " busy cycles"}, 32'(cycles), 32'd33);
      check({tag, " done"}, 32'(bus.done), 32'd1);
      check({tag, " hi"}, bus.hi, eh);
      check({tag, " lo"}, bus.lo, el);
      exp_hi = eh; exp_lo = el;
      @(posedge clk); #1;
      check({tag, " done one cycle"}, 32'(bus.done), 32'd0);
   endtask

   funct_t ops [4];

   initial begin
      logic [31:0] ra, rb;
      funct_t      rfn;
      int          done_seen;

      ops = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
      n_checks = 0; n_errors = 0;
      exp_hi = '0; exp_lo = '0;
      reset_n = 1'b0;
      bus.start = 1'b0; bus.fncode = FUNCT_MFHI; bus.a = '0; bus.b = '0;

      // Reset state
      #2;
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset hi", bus.hi, 32'd0);
      check("reset lo", bus.lo, 32'd0);
      check("reset r", bus.r, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;

      // Moves, reads and an unrelated funct code
      run_short(FUNCT_MTHI, 32'h1234_5678, "mthi");
      run_short(FUNCT_MTLO, 32'h9ABC_DEF0, "mtlo");
      bus.fncode = FUNCT_MFHI; #1;
      check("mfhi r", bus.r, 32'h1234_5678);
      bus.fncode = FUNCT_MFLO; #1;
      check("mflo r", bus.r, 32'h9ABC_DEF0);
      bus.fncode = 6'h20; #1;
      check("other r", bus.r, 32'd0);
      @(posedge clk); #1;
      run_short(6'h20, 32'hDEAD_BEEF, "ignored funct");

      // Directed arithmetic vectors
      run_long(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, FUNCT_MFHI, 32'd0, "multu max");
      check("multu max hi const", bus.hi, 32'hFFFF_FFFE);
      check("multu max lo const", bus.lo, 32'h0000_0001);
      run_long(FUNCT_MULT, 32'hFFFF_FFFE, 32'd3, 0, FUNCT_MFHI, 32'd0, "mult -2*3");
      check("mult -2*3 lo const", bus.lo, 32'hFFFF_FFFA);
      bus.fncode = FUNCT_MFHI; #1;
      check("mult -2*3 mfhi r", bus.r, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      run_long(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 0, FUNCT_MFHI, 32'd0, "div -7/2");
      check("div -7/2 lo const", bus.lo, 32'hFFFF_FFFD);
      check("div -7/2 hi const", bus.hi, 32'hFFFF_FFFF);
      run_long(FUNCT_DIVU, 32'd7, 32'd0, 0, FUNCT_MFHI, 32'd0, "divu 7/0");
      check("divu 7/0 lo const", bus.lo, 32'hFFFF_FFFF);
      run_long(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, FUNCT_MFHI, 32'd0, "div min/-1");
      check("div min/-1 lo const", bus.lo, 32'h8000_0000);
      run_long(FUNCT_DIV, 32'hFFFF_FFFB, 32'd0, 0, FUNCT_MFHI, 32'd0, "div -5/0");
      run_long(FUNCT_DIV, 32'd7, 32'hFFFF_FFFE, 0, FUNCT_MFHI, 32'd0, "div 7/-2");

      // Requests while busy are ignored
      run_long(FUNCT_DIVU, 32'd1000, 32'd7, 10, FUNCT_MTLO, 32'd5, "divu mtlo busy");
      run_long(FUNCT_MULT, 32'd12345, 32'hFFFF_0000, 5, FUNCT_MTHI, 32'd9, "mult mthi busy");
      run_long(FUNCT_MULTU, 32'd3, 32'd5, 33, FUNCT_DIVU, 32'd1, "multu start in fix");

      // Random traffic
      for (int i = 0; i < 20; i++) begin
         rfn = ops[$urandom_range(0, 3)];
         ra  = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1, 2:    rb = $urandom_range(1, 15);
            3:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         run_long(rfn, ra, rb, 0, FUNCT_MFHI, 32'd0, $sformatf("rand%0d fn%h", i, rfn));
      end

      // Reset in the middle of a multiply
      run_short(FUNCT_MTLO, 32'h0BAD_F00D, "pre-abort mtlo");
      bus.start = 1'b1; bus.fncode = FUNCT_MULT; bus.a = 32'h7000_0001; bus.b = 32'h0000_0123;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      check("abort busy cycle 20", 32'(bus.busy), 32'd1);
      reset_n = 1'b0;
      #1;
      check("abort busy", 32'(bus.busy), 32'd0);
      check("abort done", 32'(bus.done), 32'd0);
      check("abort hi", bus.hi, 32'd0);
      check("abort lo", bus.lo, 32'd0);
      exp_hi = '0; exp_lo = '0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      done_seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
         @(posedge clk); #1;
      end
      check("abort no activity", 32'(done_seen), 32'd0);
      check("abort hi kept 0", bus.hi, 32'd0);
      run_short(FUNCT_MTHI, 32'd9, "post-abort mthi");
      check("post-abort hi const", bus.hi, 32'd9);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
